// File: rtl/uart_rx_frame_parser.sv
// uart_rx_frame_parser: assembles HEADER,LEN,payload,CHK frames from a byte
// stream and releases the buffered payload only when the checksum matches.
module uart_rx_frame_parser #(
  parameter logic [7:0] HEADER      = 8'hAA,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 400
) (
  input  logic       clk_40k,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_vld,
  output logic [7:0] out_data,
  output logic       out_vld,
  output logic       out_last,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAY,
    S_CHK,
    S_DRAIN
  } state_t;

  state_t        state;
  logic          vld_q;
  logic          acc;
  logic          tout;
  logic          len_bad;
  logic [LW-1:0] len;
  logic [LW-1:0] idx;
  logic [7:0]    sum;
  logic [TW-1:0] tcnt;
  logic [7:0]    mem [MAX_LEN];

  // a byte is taken only on the rising edge of din_vld
  assign acc     = din_vld & ~vld_q;
  assign tout    = (tcnt == TW'(TIMEOUT_CYC)) && !acc;
  assign len_bad = (din == 8'd0) || (din > 8'(MAX_LEN));

  // payload store; contents are don't-care outside a frame
  always_ff @(posedge clk_40k) begin
    if (state == S_PAY && acc)
      mem[idx[AW-1:0]] <= din;
  end

  // frame FSM with registered outputs, timeout counter and checksum
  always_ff @(posedge clk_40k or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      vld_q      <= 1'b0;
      len        <= '0;
      idx        <= '0;
      sum        <= '0;
      tcnt       <= '0;
      out_data   <= '0;
      out_vld    <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= '0;
    end else begin
      vld_q      <= din_vld;
      out_vld    <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (state == S_LEN || state == S_PAY || state == S_CHK)
        tcnt <= acc ? '0 : tcnt + TW'(1);
      else
        tcnt <= '0;
      case (state)
        S_IDLE: begin
          if (acc && din == HEADER)
            state <= S_LEN;
        end
        S_LEN: begin
          if (acc) begin
            if (len_bad) begin
              frame_err <= 1'b1;
              err_code  <= 2'd1;
              state     <= S_IDLE;
            end else begin
              len   <= din[LW-1:0];
              sum   <= din;
              idx   <= '0;
              state <= S_PAY;
            end
          end else if (tout) begin
            frame_err <= 1'b1;
            err_code  <= 2'd3;
            state     <= S_IDLE;
          end
        end
        S_PAY: begin
          if (acc) begin
            sum <= sum + din;
            idx <= idx + LW'(1);
            if (idx + LW'(1) == len)
              state <= S_CHK;
          end else if (tout) begin
            frame_err <= 1'b1;
            err_code  <= 2'd3;
            state     <= S_IDLE;
          end
        end
        S_CHK: begin
          if (acc) begin
            if (din == sum) begin
              out_vld    <= 1'b1;
              out_data   <= mem[0];
              out_last   <= (len == LW'(1));
              frame_done <= (len == LW'(1));
              idx        <= LW'(1);
              state      <= S_DRAIN;
            end else begin
              frame_err <= 1'b1;
              err_code  <= 2'd2;
              state     <= S_IDLE;
            end
          end else if (tout) begin
            frame_err <= 1'b1;
            err_code  <= 2'd3;
            state     <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (idx == len) begin
            state <= S_IDLE;
          end else begin
            out_vld    <= 1'b1;
            out_data   <= mem[idx[AW-1:0]];
            out_last   <= (idx + LW'(1) == len);
            frame_done <= (idx + LW'(1) == len);
            idx        <= idx + LW'(1);
          end
          if (acc) begin
            frame_err <= 1'b1;
            err_code  <= 2'd0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// tb_uart_rx_frame_parser: directed frames with hand-computed payloads,
// checksums, error codes and output timing.
module tb_uart_rx_frame_parser;

  localparam int TIMEOUT_CYC = 400;

  logic       clk_40k = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_vld;
  logic [7:0] out_data;
  logic       out_vld;
  logic       out_last;
  logic       frame_done;
  logic       frame_err;
  logic [1:0] err_code;

  uart_rx_frame_parser #(
    .HEADER(8'hAA),
    .MAX_LEN(16),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_40k(clk_40k),
    .rst(rst),
    .din(din),
    .din_vld(din_vld),
    .out_data(out_data),
    .out_vld(out_vld),
    .out_last(out_last),
    .frame_done(frame_done),
    .frame_err(frame_err),
    .err_code(err_code)
  );

  always #5 clk_40k = ~clk_40k;

  int cyc = 0;
  always @(posedge clk_40k) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] q_d[$];
  int         q_dc[$];
  bit         q_l[$];
  bit         q_f[$];
  int         q_ec[$];
  int         q_ey[$];

  // capture everything the parser emits, stamped with the edge count
  always @(negedge clk_40k) begin
    if (!rst) begin
      if (out_vld) begin
        q_d.push_back(out_data);
        q_dc.push_back(cyc);
        q_l.push_back(out_last);
        q_f.push_back(frame_done);
      end
      if (frame_err) begin
        q_ec.push_back(int'(err_code));
        q_ey.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    q_d.delete();
    q_dc.delete();
    q_l.delete();
    q_f.delete();
    q_ec.delete();
    q_ey.delete();
  endtask

  // one-cycle strobe; acc is the edge number on which the byte is taken
  task automatic send(input logic [7:0] b, input int gap, output int acc);
    @(negedge clk_40k);
    din     = b;
    din_vld = 1'b1;
    acc     = cyc + 1;
    @(negedge clk_40k);
    din_vld = 1'b0;
    repeat (gap) @(negedge clk_40k);
  endtask

  task automatic sb(input logic [7:0] b, input int gap);
    int a;
    send(b, gap, a);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_40k);
  endtask

  initial begin
    int a;
    int ov;
    rst     = 1'b1;
    din     = '0;
    din_vld = 1'b0;
    idle(3);
    check("rst_vld", int'(out_vld), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_last", int'(out_last), 0);
    check("rst_done", int'(frame_done), 0);
    check("rst_err", int'(frame_err), 0);
    check("rst_code", int'(err_code), 0);
    rst = 1'b0;
    idle(2);

    // good frame
    clr();
    sb(8'hAA, 10); sb(8'h03, 10); sb(8'h11, 10);
    sb(8'h22, 10); sb(8'h33, 10);
    send(8'h69, 10, a);
    check("g_n", q_d.size(), 3);
    check("g_d0", int'(q_d[0]), 'h11);
    check("g_d1", int'(q_d[1]), 'h22);
    check("g_d2", int'(q_d[2]), 'h33);
    check("g_t0", q_dc[0], a);
    check("g_t2", q_dc[2], a + 2);
    check("g_last", {q_l[0], q_l[1], q_l[2]}, 3'b001);
    check("g_done", {q_f[0], q_f[1], q_f[2]}, 3'b001);
    check("g_noerr", q_ec.size(), 0);

    // checksum failure then recovery
    clr();
    sb(8'hAA, 3); sb(8'h02, 3); sb(8'h10, 3); sb(8'h20, 3);
    send(8'h00, 5, a);
    check("c_nout", q_d.size(), 0);
    check("c_nerr", q_ec.size(), 1);
    check("c_code", q_ec[0], 2);
    check("c_time", q_ey[0], a);
    sb(8'hAA, 3); sb(8'h01, 3); sb(8'h05, 3); sb(8'h06, 5);
    check("c_rec_n", q_d.size(), 1);
    check("c_rec_d", int'(q_d[0]), 'h05);
    check("c_rec_done", int'(q_f[0]), 1);

    // bad lengths
    clr();
    sb(8'hAA, 3);
    send(8'h00, 3, a);
    sb(8'hAA, 3);
    send(8'h11, 3, ov);
    sb(8'hAA, 3); sb(8'h01, 3); sb(8'h09, 3); sb(8'h0A, 5);
    check("l_nerr", q_ec.size(), 2);
    check("l_code0", q_ec[0], 1);
    check("l_code1", q_ec[1], 1);
    check("l_t0", q_ey[0], a);
    check("l_t1", q_ey[1], ov);
    check("l_rec", int'(q_d[0]), 'h09);

    // timeout and near miss
    clr();
    sb(8'hAA, 2); sb(8'h04, 2);
    send(8'h01, 0, a);
    idle(TIMEOUT_CYC + 20);
    check("t_nerr", q_ec.size(), 1);
    check("t_code", q_ec[0], 3);
    check("t_time", q_ey[0], a + TIMEOUT_CYC + 1);
    clr();
    sb(8'hAA, 2);
    sb(8'h01, TIMEOUT_CYC - 2);
    sb(8'h33, 3);
    sb(8'h34, 5);
    check("t_nm_err", q_ec.size(), 0);
    check("t_nm_d", int'(q_d[0]), 'h33);

    // held level and garbage
    clr();
    @(negedge clk_40k);
    din     = 8'hAA;
    din_vld = 1'b1;
    idle(50);
    din_vld = 1'b0;
    idle(2);
    sb(8'h01, 3); sb(8'h3C, 3); sb(8'h3D, 5);
    check("v_n", q_d.size(), 1);
    check("v_d", int'(q_d[0]), 'h3C);
    check("v_err", q_ec.size(), 0);
    clr();
    sb(8'h55, 3); sb(8'h00, 3); sb(8'hAA, 3);
    sb(8'h01, 3); sb(8'h7F, 3); sb(8'h80, 5);
    check("j_n", q_d.size(), 1);
    check("j_d", int'(q_d[0]), 'h7F);
    check("j_err", q_ec.size(), 0);

    // overrun during a 16-byte drain
    clr();
    sb(8'hAA, 2); sb(8'h10, 2);
    for (int i = 1; i <= 16; i++) sb(8'(i), 2);
    send(8'h98, 2, a);
    send(8'hAA, 0, ov);
    idle(30);
    check("o_n", q_d.size(), 16);
    for (int i = 0; i < 16; i++)
      check($sformatf("o_d%0d", i), int'(q_d[i]), i + 1);
    check("o_last", int'(q_l[15]), 1);
    check("o_tend", q_dc[15], a + 15);
    check("o_nerr", q_ec.size(), 1);
    check("o_code", q_ec[0], 0);
    check("o_time", q_ey[0], ov);
    clr();
    sb(8'hAA, 2); sb(8'h02, 2); sb(8'h42, 2);
    sb(8'h43, 2); sb(8'h87, 5);
    check("o_rec_n", q_d.size(), 2);
    check("o_rec_d1", int'(q_d[1]), 'h43);
    check("o_rec_err", q_ec.size(), 0);

    // asynchronous reset mid-drain
    sb(8'hAA, 2); sb(8'h08, 2);
    for (int i = 1; i <= 8; i++) sb(8'(i), 2);
    send(8'h2C, 0, a);
    check("r_pre_vld", int'(out_vld), 1);
    #2 rst = 1'b1;
    #1;
    check("r_vld", int'(out_vld), 0);
    check("r_data", int'(out_data), 0);
    @(negedge clk_40k);
    rst = 1'b0;
    idle(20);
    clr();

    // asynchronous reset mid-payload
    sb(8'hAA, 2); sb(8'h04, 2); sb(8'h01, 2); sb(8'h02, 2);
    #2 rst = 1'b1;
    #1;
    check("p_vld", int'(out_vld), 0);
    check("p_err", int'(frame_err), 0);
    @(negedge clk_40k);
    rst = 1'b0;
    idle(2);
    sb(8'hAA, 2); sb(8'h02, 2); sb(8'h0A, 2);
    sb(8'h0B, 2); sb(8'h17, 5);
    check("p_n", q_d.size(), 2);
    check("p_d0", int'(q_d[0]), 'h0A);
    check("p_d1", int'(q_d[1]), 'h0B);
    check("p_nerr", q_ec.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
